// File: rtl/demux_registrado.sv
// Registered 1-to-N demultiplexer with valid/ready handshakes.
// A single source word is steered by `controle` into one of N_OUT holding
// slots. Each slot keeps its word until its own consumer takes it, so the
// producer and the N consumers are timing-decoupled.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// when valid and ready are both high. A valid word is held stable, unchanged,
// until it transfers. The source side's ready (entrada_ready) is the only
// output with a combinational path from inputs. It is high when the addressed
// slot is empty or is being emptied on this same edge.
module demux_registrado #(
  parameter  int WIDTH = 32,
  parameter  int SEL_W = 2,
  localparam int N_OUT = 2 ** SEL_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       entrada,
  input  logic [SEL_W-1:0]       controle,
  input  logic                   entrada_valid,
  output logic                   entrada_ready,
  output logic [N_OUT*WIDTH-1:0] saida,
  output logic [N_OUT-1:0]       saida_valid,
  input  logic [N_OUT-1:0]       saida_ready,
  output logic [SEL_W:0]         pendentes,
  output logic                   ocupado
);

  localparam int CW = SEL_W + 1;

  // Slot storage, per-slot pending flags and the pending-slot counter.
  logic [N_OUT-1:0][WIDTH-1:0] data_q, data_d;
  logic [N_OUT-1:0]            valid_q, valid_d;
  logic [CW-1:0]               pendentes_q, pendentes_d;

  // Per-edge events, one bit per slot.
  logic             accept;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] consume;
  logic [CW-1:0]    inc_cnt;
  logic [CW-1:0]    dec_cnt;

  // Source acceptance: the addressed slot is free now or frees on this edge.
  always_comb begin
    entrada_ready = !valid_q[controle] || saida_ready[controle];
    accept        = entrada_valid && entrada_ready;
  end

  // Next-state for every slot and the pending counter.
  always_comb begin
    load        = '0;
    consume     = '0;
    valid_d     = valid_q;
    data_d      = data_q;
    inc_cnt     = '0;
    dec_cnt     = '0;
    pendentes_d = pendentes_q;
    for (int k = 0; k < N_OUT; k++) begin
      load[k]    = accept && (controle == SEL_W'(k));
      consume[k] = valid_q[k] && saida_ready[k];
      // A load wins over a consume on the same slot: refill without a bubble.
      valid_d[k] = load[k] || (valid_q[k] && !consume[k]);
      if (load[k]) begin
        data_d[k] = entrada;
      end
      // Count only net changes: a load into an empty slot adds one, a
      // consume that is not refilled on the same edge removes one.
      if (load[k] && !valid_q[k]) begin
        inc_cnt = inc_cnt + CW'(1);
      end
      if (consume[k] && !load[k]) begin
        dec_cnt = dec_cnt + CW'(1);
      end
    end
    pendentes_d = pendentes_q + inc_cnt - dec_cnt;
  end

  // State registers; reset discards every pending word and zeroes the data.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q      <= '0;
      valid_q     <= '0;
      pendentes_q <= '0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      pendentes_q <= pendentes_d;
    end
  end

  // Outputs come straight from registers; ocupado only looks at the counter.
  always_comb begin
    saida       = data_q;
    saida_valid = valid_q;
    pendentes   = pendentes_q;
    ocupado     = (pendentes_q != '0);
  end

endmodule

// File: tb/tb_demux_registrado.sv
// Bench for demux_registrado: directed scenarios followed by random traffic.
// The reference keeps one queue of outstanding words per destination slot.
// A slot is pending exactly when its queue is non-empty, and the pending
// count is the number of non-empty queues.
module tb_demux_registrado;

  localparam int WIDTH = 32;
  localparam int SEL_W = 2;
  localparam int N_OUT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic                   clock = 1'b0;
  logic                   reset;
  logic [WIDTH-1:0]       entrada;
  logic [SEL_W-1:0]       controle;
  logic                   entrada_valid;
  logic                   entrada_ready;
  logic [N_OUT*WIDTH-1:0] saida;
  logic [N_OUT-1:0]       saida_valid;
  logic [N_OUT-1:0]       saida_ready;
  logic [SEL_W:0]         pendentes;
  logic                   ocupado;

  always #5 clock = ~clock;

  demux_registrado #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .entrada      (entrada),
    .controle     (controle),
    .entrada_valid(entrada_valid),
    .entrada_ready(entrada_ready),
    .saida        (saida),
    .saida_valid  (saida_valid),
    .saida_ready  (saida_ready),
    .pendentes    (pendentes),
    .ocupado      (ocupado)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[N_OUT][$];
  logic [WIDTH-1:0] last_word[N_OUT];
  int               n_cmp = 0;
  int               n_err = 0;
  logic             last_rdy;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] slot(input int k);
    return saida[k*WIDTH +: WIDTH];
  endfunction

  // Compare every registered output against the reference.
  task automatic check_outputs(input string tag);
    logic [N_OUT-1:0] ev;
    int               cnt;
    cnt = 0;
    for (int k = 0; k < N_OUT; k++) begin
      ev[k] = (exp_q[k].size() != 0);
      if (ev[k]) cnt++;
      check($sformatf("%s slot%0d data", tag, k), slot(k), last_word[k]);
    end
    check({tag, " saida_valid"}, saida_valid, ev);
    check({tag, " pendentes"}, pendentes, cnt);
    check({tag, " ocupado"}, ocupado, cnt != 0);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive at the falling edge, check entrada_ready and any
  // consumed words just before the rising edge, update the reference at the
  // edge, then check outputs at the next falling edge.
  task automatic cycle(input string tag, input bit rst, input bit v,
                       input logic [SEL_W-1:0] c, input logic [WIDTH-1:0] d,
                       input logic [N_OUT-1:0] sr);
    bit exp_rdy;
    bit take[N_OUT];
    reset = rst; entrada_valid = v; controle = c; entrada = d; saida_ready = sr;
    #1;
    exp_rdy  = (exp_q[c].size() == 0) || sr[c];
    last_rdy = entrada_ready;
    if (!rst) check({tag, " entrada_ready"}, entrada_ready, exp_rdy);
    for (int k = 0; k < N_OUT; k++) begin
      take[k] = !rst && (exp_q[k].size() != 0) && sr[k];
      if (take[k]) check($sformatf("%s consumed slot%0d", tag, k), slot(k), exp_q[k][0]);
    end
    @(posedge clock);
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) begin
        exp_q[k].delete();
        last_word[k] = '0;
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) if (take[k]) void'(exp_q[k].pop_front());
      if (v && exp_rdy) begin
        exp_q[c].push_back(d);
        last_word[c] = d;
      end
    end
    @(negedge clock);
    check_outputs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; entrada_valid = 1'b0; controle = '0; entrada = '0; saida_ready = '0;
    for (int k = 0; k < N_OUT; k++) last_word[k] = '0;
    @(negedge clock);

    // Reset held two cycles with a live transfer presented.
    cycle("rst", 1, 1, 2'd2, 32'hDEADBEEF, 4'b0000);
    cycle("rst", 1, 1, 2'd2, 32'hDEADBEEF, 4'b0000);
    check("rst saida zero", saida, 128'h0);
    check("rst valid zero", saida_valid, 4'b0000);
    check("rst pendentes zero", pendentes, 3'd0);
    check("rst ocupado zero", ocupado, 1'b0);
    cycle("first", 0, 1, 2'd2, 32'h77, 4'b0000);
    check("first word slot2", slot(2), 32'h77);
    check("first word valid", saida_valid, 4'b0100);
    cycle("drain0", 0, 0, 2'd0, 32'h0, 4'b0100);

    // Basic routing with all consumers stalled.
    cycle("route", 0, 1, 2'd0, 32'h11, 4'b0000);
    cycle("route", 0, 1, 2'd3, 32'h22, 4'b0000);
    cycle("route", 0, 1, 2'd1, 32'h33, 4'b0000);
    check("route valid", saida_valid, 4'b1011);
    check("route slot0", slot(0), 32'h11);
    check("route slot1", slot(1), 32'h33);
    check("route slot3", slot(3), 32'h22);
    check("route pendentes", pendentes, 3'd3);
    check("route ocupado", ocupado, 1'b1);
    cycle("drain1", 0, 0, 2'd0, 32'h0, 4'b1111);

    // Backpressure on slot 2, then pass-through refill.
    cycle("bp", 0, 1, 2'd2, 32'hAA, 4'b0000);
    cycle("bp", 0, 1, 2'd2, 32'hBB, 4'b0000);
    check("bp ready low", last_rdy, 1'b0);
    check("bp slot2 held", slot(2), 32'hAA);
    cycle("bp", 0, 1, 2'd2, 32'hBB, 4'b0100);
    check("bp refill ready", last_rdy, 1'b1);
    check("bp refill slot2", slot(2), 32'hBB);
    check("bp refill valid", saida_valid, 4'b0100);
    check("bp refill pendentes", pendentes, 3'd1);

    // Independent slot while slot 2 is stalled.
    cycle("indep", 0, 1, 2'd0, 32'h5, 4'b0000);
    check("indep ready", last_rdy, 1'b1);
    check("indep slot0", slot(0), 32'h5);
    check("indep slot2", slot(2), 32'hBB);
    check("indep valid", saida_valid, 4'b0101);

    // Fill all four, then drain in one cycle.
    cycle("fill", 0, 1, 2'd1, 32'h61, 4'b0000);
    cycle("fill", 0, 1, 2'd3, 32'h63, 4'b0000);
    check("fill pendentes", pendentes, 3'd4);
    cycle("drain", 0, 0, 2'd0, 32'h0, 4'b1111);
    check("drain valid", saida_valid, 4'b0000);
    check("drain pendentes", pendentes, 3'd0);
    check("drain ocupado", ocupado, 1'b0);
    check("drain data kept", saida, {32'h63, 32'hBB, 32'h61, 32'h5});

    // Reset in the middle of traffic.
    cycle("mid", 0, 1, 2'd0, 32'h71, 4'b0000);
    cycle("mid", 0, 1, 2'd1, 32'h72, 4'b0000);
    cycle("mid", 0, 1, 2'd2, 32'h73, 4'b0000);
    cycle("midrst", 1, 1, 2'd3, 32'h74, 4'b0001);
    check("midrst saida zero", saida, 128'h0);
    check("midrst valid zero", saida_valid, 4'b0000);
    check("midrst pendentes", pendentes, 3'd0);
    cycle("after", 0, 0, 2'd0, 32'h0, 4'b1111);
    check("after no stale", saida_valid, 4'b0000);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            SEL_W'($urandom_range(0, N_OUT - 1)), $urandom,
            N_OUT'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_registrado.md
Name: demux_registrado

Overview:
- Registered 1-to-N demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the 2:1 selection muxes in the datapath.
- One 32-bit source word is routed by `controle` to exactly one of N destination slots. Each slot holds its word until that destination consumes it.
- Sits between a producing unit (ALU/memory result bus) and multiple consumers (register write-back, PC load, MDR, etc.), decoupling their timing.

Parameters:
- WIDTH, 32, data width of entrada and each saida.
- SEL_W, 2, width of controle; N_OUT = 2**SEL_W destination slots (default 4).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
- entrada  input  WIDTH  source data word.
- controle  input  SEL_W  destination slot index for the current entrada word.
- entrada_valid  input  1  source presents a word this cycle.
- entrada_ready  output  1  block accepts the word this cycle (combinational).
- saida  output  N_OUT*WIDTH  concatenated slot data; slot k occupies bits [k*WIDTH +: WIDTH].
- saida_valid  output  N_OUT  per-slot "word pending" flag.
- saida_ready  input  N_OUT  per-slot consumer acceptance.
- pendentes  output  SEL_W+1  count of slots with saida_valid set.
- ocupado  output  1  high when pendentes != 0.

Behaviour:
- Reset (reset=1 at edge): all saida slots = 0, saida_valid = 0, pendentes = 0, ocupado = 0. Reset overrides every simultaneous handshake. Reset mid-transfer discards all pending words; there is no partial state.
- Input acceptance: entrada_ready = !saida_valid[controle] || saida_ready[controle]. This is combinational and depends on the current controle.
- Input transfer: occurs when entrada_valid && entrada_ready at a clock edge. On that edge, slot[controle] <= entrada and saida_valid[controle] <= 1.
- Output transfer for slot k: occurs when saida_valid[k] && saida_ready[k] at a clock edge. saida_valid[k] <= 0 unless the same edge loads slot k.
- Simultaneous consume and load on the same slot: the new word is loaded and valid stays 1 (pass-through refill, no bubble). Throughput is 1 word/cycle per slot.
- Simultaneous load of slot j and consume of slot k (j != k): both take effect independently.
- Latency: a word accepted at edge n is visible on its saida slot with valid=1 after edge n.
- Data hold: slot data is stable while valid=1 and not consumed. After consumption the data retains its last value; only valid drops. Slot data changes only on load or reset.
- No drop/overwrite: a slot with valid=1 and saida_ready=0 stalls the source via entrada_ready=0. Stalls are per-slot; other slots stay unaffected on later cycles with a different controle.
- entrada_valid=0: controle and entrada are ignored; no state change except output consumption.
- saida_ready[k] while saida_valid[k]=0: no effect.
- pendentes: registered. It is recomputed each edge as (loads into an empty or simultaneously unconsumed slot) minus (consumes without reload). It must always equal the popcount of saida_valid; range 0..N_OUT.
- ocupado: derived from registered pendentes, with no combinational path from inputs.
- Only entrada_ready may depend combinationally on inputs; saida, saida_valid, pendentes and ocupado are registered.

Test Plan:
- Reset check: assert reset 2 cycles with entrada_valid=1, controle=2, entrada=32'hDEADBEEF.
  - Response: saida all 0, saida_valid=4'b0000, pendentes=0, ocupado=0.
  - After release, the first accepted word appears one cycle later.
- Basic routing: saida_ready=0. Send 32'h11 to slot 0, then 32'h22 to slot 3, then 32'h33 to slot 1.
  - Response: saida_valid=4'b1011, slot0=0x11, slot1=0x33, slot3=0x22, pendentes=3, ocupado=1.
- Backpressure: slot 2 holds 32'hAA with saida_ready[2]=0. Present 32'hBB to controle=2.
  - Response: entrada_ready=0 and slot2 stays 0xAA.
  - Set saida_ready[2]=1: same edge consumes 0xAA and loads 0xBB; saida_valid[2] stays 1; pendentes unchanged.
- Independent slots: slot 2 stalled. Present 32'h5 to controle=0.
  - Response: entrada_ready=1; slot0=0x5 valid next cycle; slot2 untouched.
- Drain and count: fill all 4 slots (pendentes=4), then raise saida_ready=4'b1111 for one cycle with entrada_valid=0.
  - Response: saida_valid=0, pendentes=0, ocupado=0; slot data retains the last values.
- Reset mid-operation: with 3 slots pending and a transfer in progress, assert reset for 1 cycle.
  - Response: all valid cleared, data zeroed, pendentes=0. No stale word reappears afterward.
